// File: rtl/jtkunio_rom_arb.sv
// -----------------------------------------------------------------------------
// jtkunio_rom_arb
//
// Purpose:
//   Shares one downstream ROM port between three graphics requesters
//   (object, scroll, character). A request is cs high with a stable address.
//   The arbiter grants one requester at a time, adds that requester's address
//   offset, waits for rom_ok and then latches rom_data into that requester's
//   data register. The requester's ok stays high while its cs and address
//   still match the served access.
//
// Ports:
//   rst               asynchronous active-high reset
//   clk               clock
//   obj_cs/obj_addr   object request (18-bit address)   -> obj_ok/obj_data
//   scr_cs/scr_addr   scroll request (17-bit address)   -> scr_ok/scr_data
//   chr_cs/chr_addr   character request (14-bit address) -> chr_ok/chr_data
//   rom_cs/rom_addr   downstream request, 20-bit address
//   rom_data/rom_ok   downstream read data and data valid
//
// Parameters:
//   OBJ_OFFSET, SCR_OFFSET, CHR_OFFSET  20-bit offsets added to each
//   requester's zero-extended address (sum wraps at 20 bits).
//
// Build option:
//   JTKUNIO_ROMARB_RR_EN  when defined, arbitration is round-robin (search
//   starts after the last granted requester). Otherwise fixed priority
//   obj > scr > chr and no pointer register is built.
// -----------------------------------------------------------------------------
module jtkunio_rom_arb #(
  parameter logic [19:0] OBJ_OFFSET = 20'h00000,
  parameter logic [19:0] SCR_OFFSET = 20'h40000,
  parameter logic [19:0] CHR_OFFSET = 20'h60000
) (
  input  logic        rst,
  input  logic        clk,
  // object requester
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic        obj_ok,
  output logic [31:0] obj_data,
  // scroll requester
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic        scr_ok,
  output logic [31:0] scr_data,
  // character requester
  input  logic        chr_cs,
  input  logic [13:0] chr_addr,
  output logic        chr_ok,
  output logic [31:0] chr_data,
  // downstream ROM
  output logic        rom_cs,
  output logic [19:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok
);

  localparam int NREQ = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  genvar gi;

  // Requesters gathered into index form: 0 = obj, 1 = scr, 2 = chr.
  logic [NREQ-1:0] req_cs;
  logic [17:0]     req_addr [NREQ];
  logic [19:0]     req_ofs  [NREQ];

  assign req_cs      = {chr_cs, scr_cs, obj_cs};
  assign req_addr[0] = obj_addr;
  assign req_addr[1] = {1'b0, scr_addr};
  assign req_addr[2] = {4'd0, chr_addr};
  assign req_ofs[0]  = OBJ_OFFSET;
  assign req_ofs[1]  = SCR_OFFSET;
  assign req_ofs[2]  = CHR_OFFSET;

  // FSM and access registers
  state_t      state_q, state_d;
  logic        rom_cs_q, rom_cs_d;
  logic [19:0] rom_addr_q, rom_addr_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;    // requester owning the current access
  logic [17:0] gnt_addr_q, gnt_addr_d;  // address the current access was issued for
  logic        armed_q, armed_d;        // low during the rom_ok ignore cycle

  logic [NREQ-1:0] ok;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] latch;
  logic [31:0]     data_o [NREQ];

  // Grant selection
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [17:0] sel_addr;
  logic [19:0] sel_ofs;

  // Currently granted requester view
  logic        cur_cs;
  logic [17:0] cur_addr;
  logic [19:0] cur_ofs;
  logic        cur_moved;

  // A requester already holding valid data for its current address is not
  // asking for anything new.
  assign pending = req_cs & ~ok;

  // ---------------------------------------------------------------------------
  // Per-requester served flag, served address and data register
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic        served_q, served_d;
      logic [17:0] saddr_q, saddr_d;
      logic [31:0] data_q, data_d;
      logic        addr_match;

      assign addr_match = (req_addr[gi] == saddr_q);
      assign ok[gi]     = served_q & req_cs[gi] & addr_match;
      assign data_o[gi] = data_q;

      always_comb begin
        // Served status evaporates as soon as cs drops or the address moves.
        served_d = served_q & req_cs[gi] & addr_match;
        saddr_d  = saddr_q;
        data_d   = data_q;
        if (latch[gi]) begin
          served_d = 1'b1;
          saddr_d  = req_addr[gi];
          data_d   = rom_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          served_q <= 1'b0;
          saddr_q  <= '0;
          data_q   <= '0;
        end else begin
          served_q <= served_d;
          saddr_q  <= saddr_d;
          data_q   <= data_d;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef JTKUNIO_ROMARB_RR_EN
  logic [1:0] ptr_q, ptr_d;  // index of the last granted requester

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    logic [1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = next_idx(cand);
      if (!gnt_valid && pending[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && gnt_valid) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_valid = |pending;
    gnt_idx   = 2'd0;
    if (pending[0])      gnt_idx = 2'd0;
    else if (pending[1]) gnt_idx = 2'd1;
    else if (pending[2]) gnt_idx = 2'd2;
  end
`endif

  always_comb begin
    sel_addr = req_addr[0];
    sel_ofs  = req_ofs[0];
    case (gnt_idx)
      2'd1: begin sel_addr = req_addr[1]; sel_ofs = req_ofs[1]; end
      2'd2: begin sel_addr = req_addr[2]; sel_ofs = req_ofs[2]; end
      default: ;
    endcase
  end

  always_comb begin
    cur_cs   = req_cs[0];
    cur_addr = req_addr[0];
    cur_ofs  = req_ofs[0];
    case (gnt_idx_q)
      2'd1: begin cur_cs = req_cs[1]; cur_addr = req_addr[1]; cur_ofs = req_ofs[1]; end
      2'd2: begin cur_cs = req_cs[2]; cur_addr = req_addr[2]; cur_ofs = req_ofs[2]; end
      default: ;
    endcase
  end

  assign cur_moved = (cur_addr != gnt_addr_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      gnt_idx_q  <= 2'd0;
      gnt_addr_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_addr_q <= gnt_addr_d;
      armed_q    <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!cur_cs)                   state_d = ST_IDLE;  // requester gave up
        else if (cur_moved)            state_d = ST_WAIT;  // reissue, stay
        else if (armed_q && rom_ok)    state_d = ST_IDLE;  // data delivered
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_addr_d = gnt_addr_q;
    armed_d    = armed_q;
    latch      = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          rom_cs_d   = 1'b1;
          rom_addr_d = {2'b00, sel_addr} + sel_ofs;
          gnt_idx_d  = gnt_idx;
          gnt_addr_d = sel_addr;
          armed_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!cur_cs) begin
          rom_cs_d = 1'b0;
        end else if (cur_moved) begin
          // New address while waiting: reissue and reopen the ignore cycle so
          // a rom_ok belonging to the old address cannot be latched.
          rom_addr_d = {2'b00, cur_addr} + cur_ofs;
          gnt_addr_d = cur_addr;
          armed_d    = 1'b0;
        end else if (armed_q && rom_ok) begin
          latch    = 3'b001 << gnt_idx_q;
          rom_cs_d = 1'b0;
        end else begin
          armed_d = 1'b1;
        end
      end
      default: rom_cs_d = 1'b0;
    endcase
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign obj_ok   = ok[0];
  assign scr_ok   = ok[1];
  assign chr_ok   = ok[2];
  assign obj_data = data_o[0];
  assign scr_data = data_o[1];
  assign chr_data = data_o[2];

endmodule

// File: doc/jtkunio_rom_arb.md
JTKUNIO_ROM_ARB -- requirements
Module: jtkunio_rom_arb

Interface
REQ-001 The block SHALL accept the parameter OBJ_OFFSET, default 20'h00000, added to the object requester address.
REQ-002 The block SHALL accept the parameter SCR_OFFSET, default 20'h40000, added to the scroll requester address.
REQ-003 The block SHALL accept the parameter CHR_OFFSET, default 20'h60000, added to the character requester address.
REQ-004 Ports (name direction width meaning) SHALL be:
- rst in 1: reset, asynchronous, active-high
- clk in 1: clock
- obj_cs in 1: object request
- obj_addr in 18: object address
- obj_ok out 1: object data valid
- obj_data out 32: object data
- scr_cs in 1 / scr_addr in 17 / scr_ok out 1 / scr_data out 32: scroll requester
- chr_cs in 1 / chr_addr in 14 / chr_ok out 1 / chr_data out 32: character requester
- rom_cs out 1: downstream request
- rom_addr out 20: downstream address
- rom_data in 32: downstream data
- rom_ok in 1: downstream data valid

Function
REQ-005 Requester rule: cs held high with stable addr until its ok is seen; an addr change with cs high is a new request.
REQ-006 FSM SHALL have states IDLE and WAIT.
REQ-007 IDLE: if any requester is pending (cs high and ok low), grant one per REQ-013; next edge rom_cs=1, rom_addr=zero-extended addr+offset (20-bit, wrap on overflow), state WAIT.
REQ-008 WAIT: rom_ok SHALL be ignored on the first cycle after rom_addr is loaded; from the second cycle onward, rom_ok=1 latches rom_data into the granted requester's data register, marks it served with that addr, drives rom_cs=0, and returns to IDLE.
REQ-009 Latency: cs rising at edge n, rom_cs high after edge n+1, earliest accepted rom_ok sampled at edge n+3, requester ok high after edge n+3.
REQ-010 WAIT, granted cs drops: rom_cs=0, return to IDLE, nothing latched, no ok.
REQ-011 WAIT, granted addr changes with cs high: reload rom_addr, restart the one-cycle rom_ok ignore window, stay in WAIT.
REQ-012 Ok outputs: x_ok = served_x & x_cs & (x_addr == served address); served_x clears when cs is low or the address differs. x_data holds its value until the next serve of x.
REQ-013 Default arbitration: fixed priority obj > scr > chr; non-granted requests wait and are never dropped.
REQ-014 No two requesters SHALL be granted simultaneously; a grant is evaluated only in IDLE, so one idle cycle always separates consecutive grants.

Reset
REQ-015 While rst is high: state IDLE, rom_cs=0, rom_addr=0, all ok=0, all data=0, served flags=0, round-robin pointer=obj.
REQ-016 Reset asserted in WAIT SHALL abort the access immediately; the first grant after release follows REQ-007.

Configuration
REQ-017 With JTKUNIO_ROMARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the requester after the last granted one (order obj, scr, chr, wrap); the pointer updates on every grant.
REQ-018 Without JTKUNIO_ROMARB_RR_EN, REQ-013 fixed priority SHALL apply and no pointer state SHALL exist.

Verification
REQ-019 Single obj request, obj_addr=18'h00123, rom_ok asserted 4 cycles after rom_cs -> rom_addr=20'h00123, obj_data=rom_data, obj_ok high until obj_cs low.
REQ-020 obj, scr and chr assert cs on the same cycle, fixed priority -> grant order obj, scr, chr; with RR_EN and last grant=obj -> scr, chr, obj.
REQ-021 scr_addr=17'h1FFFF with SCR_OFFSET=20'hF0000 -> rom_addr=20'h0FFFF (wrap).
REQ-022 Granted chr drops cs before rom_ok -> rom_cs low next cycle, chr_ok never high, pending obj granted next.
REQ-023 obj_addr changes 18'h10->18'h20 in WAIT; rom_ok high on the cycle of the change -> that rom_ok ignored, rom_addr=20'h00020, only data for 20'h00020 latched.
REQ-024 rst pulsed while in WAIT -> all outputs 0 asynchronously; held request is regranted after release.
